// File: rtl/mario_motion_ctrl.sv
// Player motion controller: synchronizes buttons and, once per frame, advances
// the sprite position through a walk / rise / fall state machine with gravity.
module mario_motion_ctrl #(
    parameter logic [9:0] X_MAX    = 10'd608,
    parameter logic [9:0] GROUND_Y = 10'd400,
    parameter logic [9:0] START_X  = 10'd32,
    parameter logic [3:0] WALK_SPD = 4'd2,
    parameter logic [3:0] JUMP_V   = 4'd8,
    parameter logic [3:0] GRAVITY  = 4'd1,
    parameter logic [3:0] V_MAX    = 4'd8,
    parameter logic [3:0] CUT_V    = 4'd2
) (
    input  logic       clk_25mhz,
    input  logic       RST_N,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       hide,
    output logic [9:0] spr_x,
    output logic [9:0] spr_y,
    output logic       spr_en,
    output logic       facing_left,
    output logic       airborne
);

    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [2:0]  btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic [9:0]  spr_x_q, spr_x_d, spr_y_q, spr_y_d;
    logic [3:0]  vy_q, vy_d;
    logic        facing_left_q, facing_left_d;
    logic        jump_prev_q, jump_prev_d;
    logic        spr_en_q, spr_en_d;

    logic        l_s, r_s, j_s, jump_edge;
    logic [10:0] x_up, x_dn, y_fall;
    logic [3:0]  rise_v, fall_v;
    logic [4:0]  fall_nv;

    always_ff @(posedge clk_25mhz) begin
        if (!RST_N) begin
            state_q       <= GROUND;
            btn_meta_q    <= '0;
            btn_sync_q    <= '0;
            spr_x_q       <= START_X;
            spr_y_q       <= GROUND_Y;
            vy_q          <= '0;
            facing_left_q <= 1'b0;
            jump_prev_q   <= 1'b0;
            spr_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_meta_q    <= btn_meta_d;
            btn_sync_q    <= btn_sync_d;
            spr_x_q       <= spr_x_d;
            spr_y_q       <= spr_y_d;
            vy_q          <= vy_d;
            facing_left_q <= facing_left_d;
            jump_prev_q   <= jump_prev_d;
            spr_en_q      <= spr_en_d;
        end
    end

    always_comb begin
        btn_meta_d    = {btn_jump, btn_right, btn_left};
        btn_sync_d    = btn_meta_q;
        spr_en_d      = !hide;
        state_d       = state_q;
        spr_x_d       = spr_x_q;
        spr_y_d       = spr_y_q;
        vy_d          = vy_q;
        facing_left_d = facing_left_q;
        jump_prev_d   = jump_prev_q;

        l_s       = btn_sync_q[0];
        r_s       = btn_sync_q[1];
        j_s       = btn_sync_q[2];
        jump_edge = j_s && !jump_prev_q;

        // 11-bit sums: the borrow/carry bit flags a bound crossing
        x_up    = {1'b0, spr_x_q} + 11'(WALK_SPD);
        x_dn    = {1'b0, spr_x_q} - 11'(WALK_SPD);
        rise_v  = (!j_s && vy_q > CUT_V) ? CUT_V : vy_q;
        fall_nv = {1'b0, vy_q} + 5'(GRAVITY);
        fall_v  = (fall_nv > 5'(V_MAX)) ? V_MAX : fall_nv[3:0];
        y_fall  = {1'b0, spr_y_q} + 11'(fall_v);

        if (frame_tick) begin
            jump_prev_d = j_s;
            if (l_s && !r_s) begin
                spr_x_d       = x_dn[10] ? 10'd0 : x_dn[9:0];
                facing_left_d = 1'b1;
            end else if (r_s && !l_s) begin
                spr_x_d       = (x_up > {1'b0, X_MAX}) ? X_MAX : x_up[9:0];
                facing_left_d = 1'b0;
            end

            case (state_q)
                GROUND: begin
                    if (jump_edge) begin
                        state_d = RISE;
                        vy_d    = JUMP_V;
                    end
                end
                RISE: begin
                    if (10'(rise_v) > spr_y_q) begin
                        spr_y_d = 10'd0;
                        vy_d    = 4'd0;
                        state_d = FALL;
                    end else begin
                        spr_y_d = spr_y_q - 10'(rise_v);
                        if (rise_v <= GRAVITY) begin
                            vy_d    = 4'd0;
                            state_d = FALL;
                        end else begin
                            vy_d = rise_v - GRAVITY;
                        end
                    end
                end
                FALL: begin
                    if (y_fall >= {1'b0, GROUND_Y}) begin
                        spr_y_d = GROUND_Y;
                        vy_d    = 4'd0;
                        state_d = GROUND;
                    end else begin
                        spr_y_d = y_fall[9:0];
                        vy_d    = fall_v;
                    end
                end
                default: begin
                    state_d = GROUND;
                    vy_d    = 4'd0;
                end
            endcase
        end
    end

    assign spr_x       = spr_x_q;
    assign spr_y       = spr_y_q;
    assign spr_en      = spr_en_q;
    assign facing_left = facing_left_q;
    assign airborne    = (state_q != GROUND);

endmodule

// File: doc/mario_motion_ctrl.md
Name: mario_motion_ctrl

Overview:
- Upstream of the sprite compositor. Turns player buttons into the sprite's screen position and enable once per frame.
- Produces spr_x, spr_y and spr_en (fed straight into the sprite stage) plus status flags.
- Position changes only on the end-of-frame pulse, so the sprite never tears mid-scan.
- Runs a walk/jump/fall state machine with gravity, saturating screen bounds and a fixed ground line.

Parameters:
- X_MAX, 10'd608: right bound for spr_x (640 - 32 sprite width).
- GROUND_Y, 10'd400: spr_y while standing on the ground.
- START_X, 10'd32: spr_x after reset.
- WALK_SPD, 4'd2: pixels per frame of horizontal motion.
- JUMP_V, 4'd8: initial upward velocity, in pixels per frame.
- GRAVITY, 4'd1: velocity change per frame.
- V_MAX, 4'd8: terminal fall velocity.
- CUT_V, 4'd2: velocity cap applied when jump is released during rise.

Ports:
- clk_25mhz, input, 1: pixel clock; the only clock.
- RST_N, input, 1: reset, synchronous, active-low.
- frame_tick, input, 1: one-cycle end-of-frame pulse (vga_end).
- btn_left, input, 1: asynchronous button, active-high.
- btn_right, input, 1: asynchronous button, active-high.
- btn_jump, input, 1: asynchronous button, active-high.
- hide, input, 1: when 1, the sprite is disabled.
- spr_x, output, 10: sprite left edge, in screen pixels.
- spr_y, output, 10: sprite top edge, in screen pixels.
- spr_en, output, 1: sprite enable to the compositor.
- facing_left, output, 1: last horizontal direction (1 = left).
- airborne, output, 1: 1 in RISE or FALL.

Behaviour:
- Clock and reset: one clock, clk_25mhz. RST_N is synchronous and active-low, sampled only on the rising edge of clk_25mhz. There is no asynchronous reset path.
- Reset values:
  - spr_x = START_X, spr_y = GROUND_Y, spr_en = 0.
  - facing_left = 0, airborne = 0.
  - state = GROUND, vy = 0, jump_prev = 0.
  - Synchronizer flops = 0.
- Reset asserted mid-jump restores all reset values on the next edge.
- Input synchronization: each button passes through a 2-flop synchronizer. Only the synchronized values (L, R, J) are used.
- Update timing:
  - All motion state updates only on cycles where frame_tick = 1. On every other cycle all registers hold.
  - Outputs are registered and change on the edge that samples frame_tick (latency 1 clock). They are therefore stable for the whole following visible frame.
- spr_en: registered copy of !hide, updated every cycle.
- Horizontal motion (on tick):
  - L & !R: spr_x = max(spr_x - WALK_SPD, 0), facing_left = 1.
  - R & !L: spr_x = min(spr_x + WALK_SPD, X_MAX), facing_left = 0.
  - Both or neither: spr_x and facing_left hold.
  - Compute in 11 bits so neither bound wraps.
- Jump edge detection: jump_edge = J & !jump_prev. jump_prev <= J, updated on ticks only.
- Vertical state machine (on tick; vy is 4-bit unsigned magnitude):
  - GROUND: if jump_edge, then state = RISE, vy = JUMP_V, spr_y unchanged this tick. Otherwise hold.
  - RISE:
    - If !J and vy > CUT_V, vy is first clamped to CUT_V.
    - If spr_y < vy: spr_y = 0, vy = 0, state = FALL (ceiling).
    - Else: spr_y -= vy, vy -= GRAVITY.
    - If the new vy is 0 (vy <= GRAVITY), vy = 0 and state = FALL.
  - FALL:
    - nv = min(vy + GRAVITY, V_MAX).
    - If spr_y + nv >= GROUND_Y: spr_y = GROUND_Y, vy = 0, state = GROUND.
    - Else: spr_y += nv, vy = nv.
  - No other states. Unused encodings go to GROUND.
- Combined motion: horizontal motion applies in all vertical states.
- Pulse rule: a frame_tick pulse longer than one cycle counts as multiple ticks; the source is required to produce single-cycle pulses.

Test Plan:
1. Reset, no buttons, 3 ticks -> spr_x = 32, spr_y = 400, spr_en = 1, airborne = 0, all unchanged.
2. btn_right held for 300 ticks from reset -> spr_x increases by 2 per tick and saturates at 608, facing_left = 0. Then btn_left held for 400 ticks -> spr_x saturates at 0, facing_left = 1.
3. btn_jump held continuously, from GROUND:
   - Tick 1 enters RISE with spr_y = 400.
   - Ticks 2-9 give spr_y 392, 385, 379, 374, 370, 367, 365, 364 (apex 364).
   - FALL ticks 10-17 lands at spr_y = 400 on tick 17, airborne = 0.
   - Holding jump on ground causes no re-jump until release and re-press.
4. Jump released after the 2nd RISE tick (spr_y = 385) -> vy capped to 2: next ticks give spr_y 383, 382, then FALL from 382 back to 400.
5. Pulses with frame_tick = 0 and buttons toggling -> no output change. A frame_tick pulse then gives the update one clock later.
6. Synchronous reset asserted mid-RISE -> next edge gives spr_x = 32, spr_y = 400, airborne = 0. Also check no asynchronous effect: a RST_N pulse between clock edges changes nothing.
